// File: rtl/uart_pkg.sv
// ============================================================================
// uart_pkg : shared UART constants and launch-sequencer state encoding
// Revision : 1.0
// ============================================================================
`default_nettype none

package uart_pkg;
  localparam int DEFAULT_DATA_WIDTH = 8;

  localparam logic [0:0] S_IDLE      = 1'b0;
  localparam logic [0:0] S_WAIT_DONE = 1'b1;
endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
// sync_fifo : circular FIFO with registered occupancy count and pop port
// Revision  : 1.0
// ============================================================================
`default_nettype none

module sync_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_push_data,
  input  logic                  i_pop,
  output logic [DATA_WIDTH-1:0] o_pop_data,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [DEPTH_LOG2:0]   o_count
);
  localparam int                  DEPTH      = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] CNT_ONE    = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = (DEPTH_LOG2)'(1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  push_ok;
  logic                  pop_ok;

  // Acceptance is judged on the registered count only, so a same-cycle pop
  // never makes room for a write into a full FIFO.
  assign push_ok = i_push && (count_q != FULL_COUNT);
  assign pop_ok  = i_pop && (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= i_push_data;
  end

  assign o_pop_data = mem_q[rd_ptr_q];
  assign o_full     = (count_q == FULL_COUNT);
  assign o_empty    = (count_q == '0);
  assign o_count    = count_q;
endmodule

`default_nettype wire

// File: rtl/uart_tx_fifo.sv
// ============================================================================
// uart_tx_fifo : byte FIFO plus launch sequencer feeding UART_Tx
// Revision     : 1.0
// ============================================================================
`default_nettype none

module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_wrStrobe,
  input  logic [DATA_WIDTH-1:0] i_wrByte,
  input  logic                  i_clearFlags,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [DEPTH_LOG2:0]   o_count,
  output logic                  o_overflowFlag,
  output logic                  o_txStart,
  output logic [DATA_WIDTH-1:0] o_txByte,
  input  logic                  i_txActive,
  input  logic                  i_txDoneStrobe,
  output logic                  o_busy
);
  logic [0:0]            state_q, state_d;
  logic                  tx_start_q, tx_start_d;
  logic [DATA_WIDTH-1:0] tx_byte_q, tx_byte_d;
  logic                  overflow_q, overflow_d;
  logic                  pop;
  logic [DATA_WIDTH-1:0] fifo_rd_data;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [DEPTH_LOG2:0]   fifo_count;

  sync_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_fifo (
    .i_clk       (i_clk),
    .i_reset_n   (i_reset_n),
    .i_push      (i_wrStrobe),
    .i_push_data (i_wrByte),
    .i_pop       (pop),
    .o_pop_data  (fifo_rd_data),
    .o_full      (fifo_full),
    .o_empty     (fifo_empty),
    .o_count     (fifo_count)
  );

  always_comb begin
    state_d    = state_q;
    tx_start_d = 1'b0;
    tx_byte_d  = tx_byte_q;
    pop        = 1'b0;
    overflow_d = overflow_q;
    // Set is applied after clear so a drop in the clear cycle is not lost.
    if (i_clearFlags)             overflow_d = 1'b0;
    if (i_wrStrobe && fifo_full)  overflow_d = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty && !i_txActive) begin
          pop        = 1'b1;
          tx_start_d = 1'b1;
          tx_byte_d  = fifo_rd_data;
          state_d    = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (i_txDoneStrobe) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q    <= S_IDLE;
      tx_start_q <= 1'b0;
      tx_byte_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_start_q <= tx_start_d;
      tx_byte_q  <= tx_byte_d;
      overflow_q <= overflow_d;
    end
  end

  assign o_full         = fifo_full;
  assign o_empty        = fifo_empty;
  assign o_count        = fifo_count;
  assign o_overflowFlag = overflow_q;
  assign o_txStart      = tx_start_q;
  assign o_txByte       = tx_byte_q;
  assign o_busy         = (fifo_count != '0) || (state_q == S_WAIT_DONE);
endmodule

`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
// ============================================================================
// tb_uart_tx_fifo : scoreboard bench with a behavioural UART_Tx handshake model
// Revision        : 1.0
// ============================================================================
`default_nettype none

module tb_uart_tx_fifo;
  localparam int BIT_CLKS = 30;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_strobe = 1'b0;
  logic [7:0] wr_byte = 8'h00;
  logic       clear_flags = 1'b0;
  logic       full, empty, overflow, tx_start, busy;
  logic [4:0] count;
  logic [7:0] tx_byte;
  logic       hold_active = 1'b0;
  logic       mdl_active = 1'b0;
  logic       mdl_done = 1'b0;
  logic       tx_active;
  int         mdl_timer = 0;
  logic [7:0] mdl_byte = 8'h00;
  int         n_starts = 0;
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] sb [$];

  assign tx_active = mdl_active | hold_active;

  always #5 clk = ~clk;

  uart_tx_fifo #(.DEPTH_LOG2(4), .DATA_WIDTH(8)) dut (
    .i_clk          (clk),
    .i_reset_n      (rst_n),
    .i_wrStrobe     (wr_strobe),
    .i_wrByte       (wr_byte),
    .i_clearFlags   (clear_flags),
    .o_full         (full),
    .o_empty        (empty),
    .o_count        (count),
    .o_overflowFlag (overflow),
    .o_txStart      (tx_start),
    .o_txByte       (tx_byte),
    .i_txActive     (tx_active),
    .i_txDoneStrobe (mdl_done),
    .o_busy         (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Transmitter model: each launch is checked against the scoreboard, then
  // held active for BIT_CLKS cycles before a one-cycle done strobe.
  always @(posedge clk) begin
    #2;
    if (!rst_n) begin
      mdl_active = 1'b0;
      mdl_done   = 1'b0;
      mdl_timer  = 0;
    end else begin
      mdl_done = 1'b0;
      if (tx_start) begin
        n_starts++;
        check("launch_gate", {31'b0, mdl_active | hold_active}, 32'd0);
        if (sb.size() == 0) check("sb_underflow", 32'd1, 32'd0);
        else check("tx_order", {24'b0, tx_byte}, {24'b0, sb.pop_front()});
        mdl_active = 1'b1;
        mdl_timer  = BIT_CLKS;
        mdl_byte   = tx_byte;
      end else if (mdl_active) begin
        mdl_timer--;
        if (mdl_timer == 0) begin
          check("byte_hold", {24'b0, tx_byte}, {24'b0, mdl_byte});
          mdl_active = 1'b0;
          mdl_done   = 1'b1;
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [7:0] b, input bit accept);
    wr_strobe = 1'b1;
    wr_byte   = b;
    if (accept) sb.push_back(b);
    tick();
    wr_strobe = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int cyc = 0;
    while ((busy || mdl_active || mdl_done) && cyc < 3000) begin
      tick();
      cyc++;
    end
    if (cyc >= 3000) check({tag, "_timeout"}, 32'd1, 32'd0);
    check({tag, "_sb_empty"}, sb.size(), 32'd0);
    check({tag, "_count"}, {27'b0, count}, 32'd0);
    check({tag, "_busy"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    int s0;
    int peak;
    tick(3);
    rst_n = 1'b1;
    tick(20);
    check("idle_empty", {31'b0, empty}, 32'd1);
    check("idle_count", {27'b0, count}, 32'd0);
    check("idle_busy", {31'b0, busy}, 32'd0);
    check("idle_starts", n_starts, 32'd0);

    s0 = n_starts;
    wr(8'h3F, 1'b1);
    check("single_busy", {31'b0, busy}, 32'd1);
    wait_idle("single");
    check("single_starts", n_starts - s0, 32'd1);

    s0 = n_starts;
    peak = 0;
    for (int i = 1; i <= 5; i++) begin
      wr(8'(i), 1'b1);
      if (int'(count) > peak) peak = int'(count);
    end
    check("burst_peak_4_5", {31'b0, (peak == 4 || peak == 5)}, 32'd1);
    wait_idle("burst");
    check("burst_starts", n_starts - s0, 32'd5);

    hold_active = 1'b1;
    for (int i = 0; i < 16; i++) wr(8'(8'h10 + i), 1'b1);
    check("fill_full", {31'b0, full}, 32'd1);
    check("fill_count", {27'b0, count}, 32'd16);
    check("fill_no_ovf", {31'b0, overflow}, 32'd0);
    wr(8'h20, 1'b0);
    check("ovf_set", {31'b0, overflow}, 32'd1);
    check("ovf_count", {27'b0, count}, 32'd16);
    tick(5);
    check("ovf_sticky", {31'b0, overflow}, 32'd1);
    clear_flags = 1'b1;
    tick();
    clear_flags = 1'b0;
    check("ovf_clear", {31'b0, overflow}, 32'd0);

    // Release the transmitter in the same cycle as a write into a full FIFO.
    hold_active = 1'b0;
    wr(8'h21, 1'b0);
    check("full_pop_count", {27'b0, count}, 32'd15);
    check("full_pop_ovf", {31'b0, overflow}, 32'd1);
    clear_flags = 1'b1;
    tick();
    clear_flags = 1'b0;
    wait_idle("drain16");

    hold_active = 1'b1;
    for (int i = 0; i < 8; i++) wr(8'(8'h40 + i), 1'b1);
    check("mid_count", {27'b0, count}, 32'd8);
    hold_active = 1'b0;
    wr(8'h48, 1'b1);
    check("mid_wr_pop_count", {27'b0, count}, 32'd8);
    wait_idle("drain9");
    check("no_ovf_after_mid", {31'b0, overflow}, 32'd0);

    for (int i = 0; i < 4; i++) wr(8'(8'hA0 + i), 1'b1);
    tick(10);
    check("pre_rst_busy", {31'b0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_empty", {31'b0, empty}, 32'd1);
    check("rst_full", {31'b0, full}, 32'd0);
    check("rst_count", {27'b0, count}, 32'd0);
    check("rst_start", {31'b0, tx_start}, 32'd0);
    check("rst_byte", {24'b0, tx_byte}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_ovf", {31'b0, overflow}, 32'd0);
    sb.delete();
    tick(3);
    rst_n = 1'b1;
    s0 = n_starts;
    tick(200);
    check("post_rst_starts", n_starts - s0, 32'd0);
    check("post_rst_busy", {31'b0, busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

`default_nettype wire
